// File: rtl/genius_pkg.sv
// Shared definitions for the Genius game: state encoding, LFSR polynomial
// and colour helpers. Also used by the HEX display decoder.
package genius_pkg;

    // State encoding is visible on o_state, so values are fixed
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_SHOW_ON  = 3'd2,
        ST_SHOW_OFF = 3'd3,
        ST_WAIT_KEY = 3'd4,
        ST_NEXT_LVL = 3'd5,
        ST_WIN      = 3'd6,
        ST_LOSE     = 3'd7
    } state_t;

    localparam int LFSR_W  = 16;
    localparam int TIMER_W = 28;
    localparam int LEVEL_W = 5;

    // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Fibonacci form:
    // polynomial terms 16,14,13,11 land on register bits 0,2,3,5
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;
    localparam logic [LFSR_W-1:0] LFSR_INIT = 16'h0001;

    // One LFSR step: new MSB is the parity of the tapped bits
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
        return {^(v & LFSR_TAPS), v[LFSR_W-1:1]};
    endfunction

    // Colour index to LED one-hot
    function automatic logic [3:0] colour_onehot(input logic [1:0] c);
        return 4'b0001 << c;
    endfunction

endpackage

// File: rtl/genius_lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous load (priority) and step enable.
module genius_lfsr16
    import genius_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] value
);

    // Shift register: reload from seed, otherwise advance when stepping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= LFSR_INIT;
        end else if (load) begin
            value <= seed;
        end else if (step) begin
            value <= lfsr_next(value);
        end
    end

endmodule

// File: rtl/genius_game_ctrl.sv
// Genius (Simon) game sequencer: plays a growing pseudo-random colour
// sequence on the LEDs, checks the player's key pulses and tracks win/lose.
// The sequence is regenerated from a stored seed on every replay.
module genius_game_ctrl
    import genius_pkg::*;
#(
    parameter int MAX_LEVEL     = 16,
    parameter int SHOW_TICKS    = 25_000_000,
    parameter int GAP_TICKS     = 12_500_000,
    parameter int TIMEOUT_TICKS = 150_000_000
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       i_start,
    input  logic [3:0] i_key,
    output logic [3:0] o_led,
    output logic [4:0] o_level,
    output logic [2:0] o_state,
    output logic       o_busy,
    output logic       o_win,
    output logic       o_lose
);

    localparam logic [TIMER_W-1:0] SHOW_RLD    = TIMER_W'(SHOW_TICKS - 1);
    localparam logic [TIMER_W-1:0] GAP_RLD     = TIMER_W'(GAP_TICKS - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_RLD = TIMER_W'(TIMEOUT_TICKS - 1);
    localparam logic [TIMER_W-1:0] TIMER_ONE   = TIMER_W'(1);
    localparam logic [LEVEL_W-1:0] LEVEL_ONE   = LEVEL_W'(1);
    localparam logic [LEVEL_W-1:0] LEVEL_TOP   = LEVEL_W'(MAX_LEVEL);

    state_t              state_q;
    state_t              state_d;
    logic [LEVEL_W-1:0]  level_q;
    logic [LEVEL_W-1:0]  level_d;
    logic [LEVEL_W-1:0]  idx_q;
    logic [LEVEL_W-1:0]  idx_d;
    logic [TIMER_W-1:0]  timer_q;
    logic [TIMER_W-1:0]  timer_d;
    logic [LFSR_W-1:0]   seed_q;
    logic [LFSR_W-1:0]   seed_d;
    logic [3:0]          led_q;
    logic [3:0]          led_d;
    logic                busy_q;
    logic                busy_d;
    logic                win_q;
    logic                win_d;
    logic                lose_q;
    logic                lose_d;

    logic [LFSR_W-1:0]   free_val;
    logic [LFSR_W-1:0]   play_val;
    logic [LFSR_W-1:0]   play_nxt;
    logic                play_load;
    logic                play_step;
    logic [1:0]          play_col;
    logic [1:0]          nxt_col;
    logic [3:0]          want_key;
    logic                last_step;
    logic                timer_zero;
    logic                key_any;
    logic                key_match;

    // Free-running generator: its value at start time becomes the game seed
    genius_lfsr16 u_free_lfsr (
        .clk   (CLOCK_50),
        .rst_n (RESET_N),
        .load  (1'b0),
        .step  (1'b1),
        .seed  ('0),
        .value (free_val)
    );

    // Playback/check generator: reloaded from the seed for each pass
    genius_lfsr16 u_play_lfsr (
        .clk   (CLOCK_50),
        .rst_n (RESET_N),
        .load  (play_load),
        .step  (play_step),
        .seed  (seed_q),
        .value (play_val)
    );

    assign play_nxt   = lfsr_next(play_val);
    assign play_col   = play_val[1:0];
    assign nxt_col    = play_nxt[1:0];
    assign want_key   = colour_onehot(play_col);
    // level is at least 1 whenever this is consulted, so level-1 never wraps
    assign last_step  = (idx_q == (level_q - LEVEL_ONE));
    assign timer_zero = (timer_q == '0);
    assign key_any    = (i_key != 4'b0000);
    assign key_match  = (i_key == want_key);

    // Next-state, counter and LED decisions for every state
    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        idx_d     = idx_q;
        timer_d   = timer_q;
        seed_d    = seed_q;
        led_d     = 4'b0000;
        play_load = 1'b0;
        play_step = 1'b0;

        case (state_q)
            ST_IDLE, ST_WIN, ST_LOSE: begin
                if (state_q == ST_WIN) begin
                    led_d = 4'hF;
                end
                if (i_start) begin
                    // A zero seed would lock the LFSR, so substitute the init value
                    seed_d  = (free_val == '0) ? LFSR_INIT : free_val;
                    level_d = LEVEL_ONE;
                    idx_d   = '0;
                    led_d   = 4'b0000;
                    state_d = ST_LOAD;
                end
            end

            ST_LOAD: begin
                play_load = 1'b1;
                idx_d     = '0;
                timer_d   = SHOW_RLD;
                // Play LFSR takes the seed on this edge, so show the seed's colour
                led_d     = colour_onehot(seed_q[1:0]);
                state_d   = ST_SHOW_ON;
            end

            ST_SHOW_ON: begin
                if (timer_zero) begin
                    timer_d = GAP_RLD;
                    state_d = ST_SHOW_OFF;
                end else begin
                    timer_d = timer_q - TIMER_ONE;
                    led_d   = colour_onehot(play_col);
                end
            end

            ST_SHOW_OFF: begin
                if (timer_zero) begin
                    if (last_step) begin
                        // Rewind the sequence so the player's keys are checked from colour 0
                        play_load = 1'b1;
                        idx_d     = '0;
                        timer_d   = TIMEOUT_RLD;
                        state_d   = ST_WAIT_KEY;
                    end else begin
                        play_step = 1'b1;
                        idx_d     = idx_q + LEVEL_ONE;
                        timer_d   = SHOW_RLD;
                        led_d     = colour_onehot(nxt_col);
                        state_d   = ST_SHOW_ON;
                    end
                end else begin
                    timer_d = timer_q - TIMER_ONE;
                end
            end

            ST_WAIT_KEY: begin
                // A key press wins over a simultaneous timeout
                if (key_any) begin
                    if (key_match) begin
                        led_d   = i_key;
                        timer_d = TIMEOUT_RLD;
                        if (last_step) begin
                            state_d = ST_NEXT_LVL;
                        end else begin
                            idx_d     = idx_q + LEVEL_ONE;
                            play_step = 1'b1;
                        end
                    end else begin
                        state_d = ST_LOSE;
                    end
                end else if (timer_zero) begin
                    state_d = ST_LOSE;
                end else begin
                    timer_d = timer_q - TIMER_ONE;
                end
            end

            ST_NEXT_LVL: begin
                if (level_q == LEVEL_TOP) begin
                    led_d   = 4'hF;
                    state_d = ST_WIN;
                end else begin
                    level_d = level_q + LEVEL_ONE;
                    state_d = ST_LOAD;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status flags follow the state being entered so they line up with o_state
    always_comb begin
        busy_d = 1'b0;
        win_d  = 1'b0;
        lose_d = 1'b0;
        busy_d = (state_d inside {ST_LOAD, ST_SHOW_ON, ST_SHOW_OFF, ST_WAIT_KEY, ST_NEXT_LVL});
        win_d  = (state_d == ST_WIN);
        lose_d = (state_d == ST_LOSE);
    end

    // State register
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Game counters, seed and registered outputs
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            level_q <= '0;
            idx_q   <= '0;
            timer_q <= '0;
            seed_q  <= LFSR_INIT;
            led_q   <= 4'b0000;
            busy_q  <= 1'b0;
            win_q   <= 1'b0;
            lose_q  <= 1'b0;
        end else begin
            level_q <= level_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
            seed_q  <= seed_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            win_q   <= win_d;
            lose_q  <= lose_d;
        end
    end

    assign o_led   = led_q;
    assign o_level = level_q;
    assign o_state = state_q;
    assign o_busy  = busy_q;
    assign o_win   = win_q;
    assign o_lose  = lose_q;

endmodule

// File: tb/tb_genius_game_ctrl.sv
// Bench for genius_game_ctrl: a game-level model predicts every output each
// cycle; directed scenarios add hand-computed literal expectations.
module tb_genius_game_ctrl;

    localparam int MAX_LEVEL     = 3;
    localparam int SHOW_TICKS    = 4;
    localparam int GAP_TICKS     = 2;
    localparam int TIMEOUT_TICKS = 20;

    logic       CLOCK_50 = 1'b0;
    logic       RESET_N  = 1'b0;
    logic       i_start  = 1'b0;
    logic [3:0] i_key    = 4'b0000;
    logic [3:0] o_led;
    logic [4:0] o_level;
    logic [2:0] o_state;
    logic       o_busy;
    logic       o_win;
    logic       o_lose;

    genius_game_ctrl #(
        .MAX_LEVEL     (MAX_LEVEL),
        .SHOW_TICKS    (SHOW_TICKS),
        .GAP_TICKS     (GAP_TICKS),
        .TIMEOUT_TICKS (TIMEOUT_TICKS)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .i_start  (i_start),
        .i_key    (i_key),
        .o_led    (o_led),
        .o_level  (o_level),
        .o_state  (o_state),
        .o_busy   (o_busy),
        .o_win    (o_win),
        .o_lose   (o_lose)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [3:0] led;
        logic [4:0] level;
        logic [2:0] state;
        logic       busy;
        logic       win;
        logic       lose;
    } obs_t;

    // Model phases of a game (not the DUT's state machine)
    localparam int M_IDLE = 0, M_PLAY = 1, M_WAIT = 2, M_NEXT = 3, M_WON = 4, M_LOST = 5;

    int          m_mode  = M_IDLE;
    obs_t        m_exp   = '0;
    obs_t        m_sched[$];
    logic [15:0] m_free  = 16'h0001;
    logic [15:0] m_seed  = 16'h0001;
    logic [15:0] m_f     = 16'h0001;
    int          m_level = 0;
    int          m_step  = 0;
    int          m_left  = 0;
    obs_t        c_got;

    // x^16+x^14+x^13+x^11+1 shifting toward bit 0
    function automatic logic [15:0] poly_step(input logic [15:0] v);
        return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    endfunction

    // Colour k of the game started from seed
    function automatic logic [1:0] colour_at(input logic [15:0] seed, input int k);
        logic [15:0] v;
        v = seed;
        for (int i = 0; i < k; i++) v = poly_step(v);
        return v[1:0];
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] c);
        return 4'b0001 << c;
    endfunction

    function automatic obs_t mk(input logic [3:0] led, input logic [2:0] st, input int lvl,
                                input logic busy, input logic win, input logic lose);
        obs_t o;
        o.led   = led;
        o.level = 5'(lvl);
        o.state = st;
        o.busy  = busy;
        o.win   = win;
        o.lose  = lose;
        return o;
    endfunction

    // Whole playback of the current level as a cycle-by-cycle timeline
    task automatic start_level();
        m_sched.delete();
        m_sched.push_back(mk(4'b0000, 3'd1, m_level, 1'b1, 1'b0, 1'b0));
        for (int k = 0; k < m_level; k++) begin
            for (int s = 0; s < SHOW_TICKS; s++)
                m_sched.push_back(mk(onehot(colour_at(m_seed, k)), 3'd2, m_level, 1'b1, 1'b0, 1'b0));
            for (int g = 0; g < GAP_TICKS; g++)
                m_sched.push_back(mk(4'b0000, 3'd3, m_level, 1'b1, 1'b0, 1'b0));
        end
        m_exp  = m_sched.pop_front();
        m_mode = M_PLAY;
    endtask

    task automatic model_lose();
        m_mode = M_LOST;
        m_exp  = mk(4'b0000, 3'd7, m_level, 1'b0, 1'b0, 1'b1);
    endtask

    // Game model: advances on every clock edge from the inputs it sees there
    initial forever begin
        @(posedge CLOCK_50 or negedge RESET_N);
        if (!RESET_N) begin
            m_mode  = M_IDLE;
            m_exp   = '0;
            m_free  = 16'h0001;
            m_level = 0;
            m_sched.delete();
        end else begin
            m_f    = m_free;
            m_free = poly_step(m_free);
            case (m_mode)
                M_IDLE, M_WON, M_LOST: begin
                    if (i_start) begin
                        m_seed  = (m_f == 16'h0000) ? 16'h0001 : m_f;
                        m_level = 1;
                        start_level();
                    end
                end
                M_PLAY: begin
                    if (m_sched.size() > 0) begin
                        m_exp = m_sched.pop_front();
                    end else begin
                        m_mode = M_WAIT;
                        m_step = 0;
                        m_left = TIMEOUT_TICKS;
                        m_exp  = mk(4'b0000, 3'd4, m_level, 1'b1, 1'b0, 1'b0);
                    end
                end
                M_WAIT: begin
                    if (i_key != 4'b0000) begin
                        if (i_key == onehot(colour_at(m_seed, m_step))) begin
                            if (m_step == m_level - 1) begin
                                m_mode = M_NEXT;
                                m_exp  = mk(i_key, 3'd5, m_level, 1'b1, 1'b0, 1'b0);
                            end else begin
                                m_step++;
                                m_left = TIMEOUT_TICKS;
                                m_exp  = mk(i_key, 3'd4, m_level, 1'b1, 1'b0, 1'b0);
                            end
                        end else begin
                            model_lose();
                        end
                    end else if (m_left == 1) begin
                        model_lose();
                    end else begin
                        m_left--;
                        m_exp = mk(4'b0000, 3'd4, m_level, 1'b1, 1'b0, 1'b0);
                    end
                end
                M_NEXT: begin
                    if (m_level == MAX_LEVEL) begin
                        m_mode = M_WON;
                        m_exp  = mk(4'hF, 3'd6, m_level, 1'b0, 1'b1, 1'b0);
                    end else begin
                        m_level++;
                        start_level();
                    end
                end
                default: m_mode = M_IDLE;
            endcase
        end
    end

    // Per-cycle comparison of all outputs against the model, mid-cycle
    initial forever begin
        @(negedge CLOCK_50);
        if (RESET_N) begin
            c_got = {o_led, o_level, o_state, o_busy, o_win, o_lose};
            n_cmp++;
            if (c_got !== m_exp) begin
                n_bad++;
                $display("FAIL cycle t=%0t: got led=%b lvl=%0d st=%0d busy=%b win=%b lose=%b, required led=%b lvl=%0d st=%0d busy=%b win=%b lose=%b",
                         $time, c_got.led, c_got.level, c_got.state, c_got.busy, c_got.win, c_got.lose,
                         m_exp.led, m_exp.level, m_exp.state, m_exp.busy, m_exp.win, m_exp.lose);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget);
        int t;
        t = 0;
        while (o_state !== st && t < budget) begin
            @(negedge CLOCK_50);
            t++;
        end
        if (o_state !== st) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_state: o_state=%0d required %0d within %0d cycles", o_state, st, budget);
        end
    endtask

    task automatic press(input logic [3:0] k);
        i_key = k;
        @(negedge CLOCK_50);
        i_key = 4'b0000;
        @(negedge CLOCK_50);
    endtask

    // Reference player: enter the correct colours for one level
    task automatic play_level(input int lvl);
        wait_state(3'd4, 200);
        check("level_in_wait", o_level, lvl);
        for (int k = 0; k < lvl; k++) press(onehot(colour_at(m_seed, k)));
    endtask

    initial begin
        logic [1:0] wc;
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] wc;
        repeat (3) @(negedge CLOCK_50);
        check("rst_led", o_led, 0);
        check("rst_level", o_level, 0);
        check("rst_state", o_state, 0);
        check("rst_flags", {o_busy, o_win, o_lose}, 0);

        // Reset mid-SHOW_ON clears outputs immediately
        RESET_N = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        i_start = 1'b1;
        @(negedge CLOCK_50);
        i_start = 1'b0;
        wait_state(3'd2, 50);
        @(posedge CLOCK_50);
        #2 RESET_N = 1'b0;
        #1;
        check("t1_led", o_led, 0);
        check("t1_level", o_level, 0);
        check("t1_state", o_state, 0);
        check("t1_flags", {o_busy, o_win, o_lose}, 0);

        // Start on the first edge after reset: seed 1 shows colour 1 first
        @(negedge CLOCK_50);
        RESET_N = 1'b1;
        i_start = 1'b1;
        @(negedge CLOCK_50);
        i_start = 1'b0;
        check("t2_load", o_state, 1);
        for (int i = 0; i < SHOW_TICKS; i++) begin
            @(negedge CLOCK_50);
            check("t2_show_led", o_led, 4'b0010);
            check("t2_show_state", o_state, 2);
        end
        for (int i = 0; i < GAP_TICKS; i++) begin
            @(negedge CLOCK_50);
            check("t2_gap_led", o_led, 0);
        end
        @(negedge CLOCK_50);
        check("t2_wait", o_state, 4);

        // Full game won; seed 1 gives colours 1,0,0
        press(4'b0010);
        play_level(2);
        play_level(3);
        check("t3_win", o_win, 1);
        check("t3_led", o_led, 4'hF);
        check("t3_level", o_level, 3);
        check("t3_state", o_state, 6);

        // Wrong key at first step of level 2
        i_start = 1'b1;
        @(negedge CLOCK_50);
        i_start = 1'b0;
        check("t4_restart_state", o_state, 1);
        check("t4_restart_win", o_win, 0);
        play_level(1);
        wait_state(3'd4, 200);
        wc = colour_at(m_seed, 0) + 2'd1;
        i_key = onehot(wc);
        @(negedge CLOCK_50);
        i_key = 4'b0000;
        check("t4_lose", o_lose, 1);
        check("t4_level", o_level, 2);
        check("t4_busy", o_busy, 0);
        check("t4_state", o_state, 7);

        // Timeout after exactly TIMEOUT_TICKS cycles in WAIT_KEY
        i_start = 1'b1;
        @(negedge CLOCK_50);
        i_start = 1'b0;
        wait_state(3'd4, 200);
        repeat (TIMEOUT_TICKS - 1) @(negedge CLOCK_50);
        check("t5_still_wait", o_state, 4);
        @(negedge CLOCK_50);
        check("t5_timeout", o_state, 7);
        check("t5_lose", o_lose, 1);

        // Correct key on the last allowed cycle
        i_start = 1'b1;
        @(negedge CLOCK_50);
        i_start = 1'b0;
        wait_state(3'd4, 200);
        repeat (TIMEOUT_TICKS - 1) @(negedge CLOCK_50);
        i_key = onehot(colour_at(m_seed, 0));
        @(negedge CLOCK_50);
        i_key = 4'b0000;
        check("t5_key_last_state", o_state, 5);
        check("t5_key_last_lose", o_lose, 0);

        // Keys and start ignored during playback; two-bit key loses
        wait_state(3'd2, 50);
        i_key   = 4'b1111;
        i_start = 1'b1;
        @(negedge CLOCK_50);
        i_key   = 4'b0000;
        i_start = 1'b0;
        check("t6_show_kept", o_state, 2);
        check("t6_show_level", o_level, 2);
        wait_state(3'd4, 200);
        i_key = 4'b0011;
        @(negedge CLOCK_50);
        i_key = 4'b0000;
        check("t6_multi_lose", o_state, 7);
        i_start = 1'b1;
        @(negedge CLOCK_50);
        i_start = 1'b0;
        check("t6_restart_state", o_state, 1);
        check("t6_restart_level", o_level, 1);
        check("t6_restart_lose", o_lose, 0);
        repeat (5) @(negedge CLOCK_50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
